// File: rtl/calc1_port_driver.sv
// calc1_port_driver
// Upstream request stage for a single calc1 request port. It takes one
// complete operation (cmd, operand1, operand2) on a valid/ready interface and
// drives it onto calc1's two-cycle request bus: cmd with operand1, then
// operand2. It then waits for the out_respN/out_dataN reply and holds the
// result on a valid/ready interface until it is taken. Only one operation is
// outstanding at a time. If calc1 does not answer within TIMEOUT_CYCLES
// cycles, the block produces a timeout result. All outputs are registered.

module calc1_port_driver #(
  // Cycles spent in WAIT_RESP before giving up (legal range 2..255).
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  // operation intake
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_cmd,
  input  logic [31:0] op_data1,
  input  logic [31:0] op_data2,
  // calc1 request bus
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  // calc1 response bus
  input  logic [1:0]  resp_in,
  input  logic [31:0] data_in,
  // result delivery
  output logic        res_valid,
  input  logic        res_ready,
  output logic [1:0]  res_resp,
  output logic [31:0] res_data,
  output logic        res_timeout,
  output logic        spurious
);

  typedef enum logic [2:0] {
    IDLE,
    SEND1,
    SEND2,
    WAIT_RESP,
    HOLD
  } state_e;

  // calc1 response codes
  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;

  // The last timer value that is still inside the wait window.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic        op_ready_q;
  logic [3:0]  req_cmd_q;
  logic [31:0] req_data_q;
  logic [31:0] op_data2_q;
  logic [7:0]  timer_q;
  logic        res_valid_q;
  logic [1:0]  res_resp_q;
  logic [31:0] res_data_q;
  logic        res_timeout_q;
  logic        spurious_q;

  logic        resp_seen;
  logic        timer_expired;
  logic        accept;
  logic        spurious_d;
  logic [1:0]  cap_resp_d;
  logic [31:0] cap_data_d;
  logic        cap_timeout_d;

  // Decode the reply and prepare the values captured when WAIT_RESP ends.
  // A response on the final timer cycle wins because only resp_in selects
  // the captured values. Timeout produces code 0, data 0 and the timeout flag.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned; a missing default here would infer a latch.
    resp_seen     = 1'b0;
    timer_expired = 1'b0;
    accept        = 1'b0;
    spurious_d    = spurious_q;
    cap_resp_d    = RESP_NONE;
    cap_data_d    = '0;
    cap_timeout_d = 1'b0;

    resp_seen     = (resp_in != RESP_NONE);
    timer_expired = (timer_q == TIMER_LAST);
    accept        = (state_q == IDLE) && op_valid && op_ready_q;

    // Any reply outside the wait window is flagged and kept until reset.
    if (resp_seen && (state_q != WAIT_RESP)) begin
      spurious_d = 1'b1;
    end

    cap_resp_d    = resp_in;
    cap_data_d    = (resp_in == RESP_OK) ? data_in : 32'd0;
    cap_timeout_d = !resp_seen;
  end

  // Hold the second operand for the SEND2 beat; it is consumed only after an accept.
  // NOTE: this is a pure data-holding register that is always written before it is read, so it has no reset and stays out of the reset fan-out.
  always_ff @(posedge c_clk) begin
    if (accept) begin
      op_data2_q <= op_data2;
    end
  end

  // Request/response sequencer. Every output is a register that is updated here.
  always_ff @(posedge c_clk) begin
    // NOTE: all sequential state uses non-blocking assignment, so each branch reads the pre-edge values of the registers.
    if (reset) begin
      state_q       <= IDLE;
      op_ready_q    <= 1'b0;
      req_cmd_q     <= 4'd0;
      req_data_q    <= 32'd0;
      timer_q       <= 8'd0;
      res_valid_q   <= 1'b0;
      res_resp_q    <= RESP_NONE;
      res_data_q    <= 32'd0;
      res_timeout_q <= 1'b0;
      spurious_q    <= 1'b0;
    end else begin
      spurious_q <= spurious_d;

      case (state_q)
        IDLE: begin
          if (accept) begin
            // Beat 1: command with the first operand.
            op_ready_q <= 1'b0;
            req_cmd_q  <= op_cmd;
            req_data_q <= op_data1;
            state_q    <= SEND1;
          end else begin
            op_ready_q <= 1'b1;
          end
        end

        SEND1: begin
          // Beat 2: command cleared, second operand.
          req_cmd_q  <= 4'd0;
          req_data_q <= op_data2_q;
          state_q    <= SEND2;
        end

        SEND2: begin
          // Release the bus and start the response timer from zero.
          req_cmd_q  <= 4'd0;
          req_data_q <= 32'd0;
          timer_q    <= 8'd0;
          state_q    <= WAIT_RESP;
        end

        WAIT_RESP: begin
          if (resp_seen || timer_expired) begin
            res_valid_q   <= 1'b1;
            res_resp_q    <= cap_resp_d;
            res_data_q    <= cap_data_d;
            res_timeout_q <= cap_timeout_d;
            state_q       <= HOLD;
          end else begin
            // The timeout fires before the counter can reach its top value, so it never wraps.
            timer_q <= timer_q + 8'd1;
          end
        end

        HOLD: begin
          // The result stays stable until the consumer takes it; the next accept can happen one cycle later.
          if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
            op_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          op_ready_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign op_ready     = op_ready_q;
  assign req_cmd_out  = req_cmd_q;
  assign req_data_out = req_data_q;
  assign res_valid    = res_valid_q;
  assign res_resp     = res_resp_q;
  assign res_data     = res_data_q;
  assign res_timeout  = res_timeout_q;
  assign spurious     = spurious_q;

endmodule

// File: tb/tb_calc1_port_driver.sv
// tb_calc1_port_driver
// Directed bench for calc1_port_driver with TIMEOUT_CYCLES=8. The bench
// drives inputs and samples outputs on the falling clock edge. The calc1
// reply is hand-placed a known number of cycles after the request.

module tb_calc1_port_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_cmd;
  logic [31:0] op_data1;
  logic [31:0] op_data2;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  resp_in;
  logic [31:0] data_in;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_resp;
  logic [31:0] res_data;
  logic        res_timeout;
  logic        spurious;

  int n_cmp = 0;
  int n_bad = 0;

  calc1_port_driver #(.TIMEOUT_CYCLES(8)) dut (
    .c_clk        (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_cmd       (op_cmd),
    .op_data1     (op_data1),
    .op_data2     (op_data2),
    .req_cmd_out  (req_cmd_out),
    .req_data_out (req_data_out),
    .resp_in      (resp_in),
    .data_in      (data_in),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_resp     (res_resp),
    .res_data     (res_data),
    .res_timeout  (res_timeout),
    .spurious     (spurious)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got running, expected done)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Move to the next falling edge, past one rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_op_ready"},   op_ready,     0);
    check({tag, "_req_cmd"},    req_cmd_out,  0);
    check({tag, "_req_data"},   req_data_out, 0);
    check({tag, "_res_valid"},  res_valid,    0);
    check({tag, "_res_resp"},   res_resp,     0);
    check({tag, "_res_data"},   res_data,     0);
    check({tag, "_res_timeout"}, res_timeout, 0);
    check({tag, "_spurious"},   spurious,     0);
  endtask

  // Present an operation and wait for it to be accepted. Then check both request
  // beats and the bus release. The task returns at the falling edge just after
  // the bench enters WAIT_RESP.
  task automatic send_op(input string tag, input logic [3:0] cmd,
                         input logic [31:0] d1, input logic [31:0] d2);
    int n;
    op_cmd   = cmd;
    op_data1 = d1;
    op_data2 = d2;
    op_valid = 1'b1;
    n = 0;
    while (op_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check({tag, "_accept_wait"}, op_ready, 1);
    tick();
    op_valid = 1'b0;
    op_cmd   = 4'hF;
    op_data1 = 32'hDEAD_BEEF;
    op_data2 = 32'hDEAD_BEEF;
    check({tag, "_beat1_cmd"},  req_cmd_out,  cmd);
    check({tag, "_beat1_data"}, req_data_out, d1);
    check({tag, "_beat1_rdy"},  op_ready,     0);
    tick();
    check({tag, "_beat2_cmd"},  req_cmd_out,  0);
    check({tag, "_beat2_data"}, req_data_out, d2);
    tick();
    check({tag, "_idle_cmd"},   req_cmd_out,  0);
    check({tag, "_idle_data"},  req_data_out, 0);
  endtask

  // Let the request sit for 'delay' silent wait cycles, then present one reply beat.
  task automatic respond(input string tag, input int delay, input logic [1:0] resp,
                         input logic [31:0] data, input logic [1:0] exp_resp,
                         input logic [31:0] exp_data);
    for (int i = 0; i < delay; i++) begin
      check({tag, "_wait_valid"}, res_valid, 0);
      tick();
    end
    resp_in = resp;
    data_in = data;
    tick();
    resp_in = 2'd0;
    data_in = 32'h5A5A_5A5A;
    check({tag, "_res_valid"},   res_valid,    1);
    check({tag, "_res_resp"},    res_resp,     exp_resp);
    check({tag, "_res_data"},    res_data,     exp_data);
    check({tag, "_res_timeout"}, res_timeout,  0);
    check({tag, "_bus_quiet"},   req_data_out, 0);
  endtask

  task automatic take_result(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, res_valid, 0);
    check({tag, "_ready_back"}, op_ready,  1);
  endtask

  initial begin
    reset     = 1'b1;
    op_valid  = 1'b0;
    op_cmd    = 4'd0;
    op_data1  = 32'd0;
    op_data2  = 32'd0;
    resp_in   = 2'd0;
    data_in   = 32'd0;
    res_ready = 1'b0;
    @(negedge clk);
    tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();
    check("post_reset_ready", op_ready, 1);

    // Add: a reply three cycles into the wait window.
    send_op("add", 4'd1, 32'h0000_0001, 32'h01FF_FFFF);
    respond("add", 3, 2'd1, 32'h0200_0000, 2'd1, 32'h0200_0000);
    take_result("add");
    check("add_spurious", spurious, 0);

    // Overflow: response code 2 clears the data even though data_in is nonzero.
    send_op("ovf", 4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
    respond("ovf", 1, 2'd2, 32'h1234_5678, 2'd2, 32'h0000_0000);
    take_result("ovf");

    // Timeout: no reply, so the result appears eight edges after the SEND2 edge.
    send_op("tmo", 4'd6, 32'h0000_0080, 32'h0000_0003);
    for (int i = 0; i < 7; i++) begin
      check("tmo_no_valid", res_valid, 0);
      check("tmo_not_ready", op_ready, 0);
      tick();
    end
    check("tmo_no_valid_last", res_valid, 0);
    tick();
    check("tmo_valid",   res_valid,   1);
    check("tmo_resp",    res_resp,    0);
    check("tmo_data",    res_data,    0);
    check("tmo_flag",    res_timeout, 1);
    check("tmo_ready",   op_ready,    0);

    // Backpressure: the timeout result is held for 5 cycles while a new op waits.
    op_cmd   = 4'd2;
    op_data1 = 32'h0000_0009;
    op_data2 = 32'h0000_0004;
    op_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_held", res_valid,   1);
      check("bp_flag_held",  res_timeout, 1);
      check("bp_not_ready",  op_ready,    0);
      check("bp_bus_quiet",  req_cmd_out, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_valid_drop", res_valid, 0);
    check("bp_ready_back", op_ready,  1);
    send_op("bp_sub", 4'd2, 32'h0000_0009, 32'h0000_0004);
    respond("bp_sub", 0, 2'd1, 32'h0000_0005, 2'd1, 32'h0000_0005);
    take_result("bp_sub");

    // A reply on the final timer cycle takes priority over the timeout.
    send_op("edge", 4'd5, 32'h0000_0003, 32'h0000_0002);
    respond("edge", 7, 2'd1, 32'h0000_000C, 2'd1, 32'h0000_000C);
    take_result("edge");

    // A reply while the result is held is flagged and does not change the result.
    send_op("hold", 4'd1, 32'h0000_0002, 32'h0000_0002);
    respond("hold", 0, 2'd1, 32'h0000_0004, 2'd1, 32'h0000_0004);
    resp_in = 2'd1;
    data_in = 32'h0000_0099;
    tick();
    resp_in = 2'd0;
    check("hold_spur_flag", spurious, 1);
    check("hold_data_kept", res_data, 32'h0000_0004);
    take_result("hold");

    // Reset mid-op: the reset clears the spurious flag, and a late reply sets it again.
    send_op("rst", 4'd6, 32'h0000_0100, 32'h0000_0001);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_reset_values("midop");
    reset   = 1'b0;
    resp_in = 2'd1;
    data_in = 32'h0000_0080;
    tick();
    resp_in = 2'd0;
    check("late_spurious", spurious,  1);
    check("late_no_valid", res_valid, 0);
    check("late_ready",    op_ready,  1);
    tick();
    check("late_no_valid2", res_valid, 0);
    check("late_sticky",    spurious,  1);

    // Back-to-back: three queued ops with the consumer always ready.
    res_ready = 1'b1;
    send_op("b2b0", 4'd1, 32'd0, 32'd0);
    respond("b2b0", 1, 2'd1, 32'd0, 2'd1, 32'd0);
    send_op("b2b1", 4'd2, 32'd1, 32'd15);
    respond("b2b1", 2, 2'd2, 32'hFFFF_FFF2, 2'd2, 32'd0);
    send_op("b2b2", 4'd5, 32'd1, 32'd4);
    respond("b2b2", 0, 2'd1, 32'd16, 2'd1, 32'd16);
    tick();
    res_ready = 1'b0;
    check("b2b_done_valid", res_valid, 0);
    check("b2b_done_ready", op_ready,  1);

    // Only a reset clears the spurious flag.
    reset = 1'b1;
    tick();
    check("final_rst_spur", spurious, 0);
    check("final_rst_rdy",  op_ready, 0);
    reset = 1'b0;
    tick();
    check("final_ready", op_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
